// File: rtl/vid_palette_pkg.sv
// Shared types and derived constants for the multi-channel video palette.
package vid_palette_pkg;

    // Bank-swap controller state encoding.
    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    // The bank bit sits directly above the entry index in the physical address.
    function automatic int bank_bit_pos(input int addr_w);
        return addr_w;
    endfunction

    // One write strobe per byte lane.
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/vid_palette_copy.sv
// One palette RAM copy: port A is the CPU side (byte-enable write, read-first
// registered read), port B is a read-only registered video lookup.
module vid_palette_copy
    import vid_palette_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PA_W   = 10
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        a_en,
    input  logic [PA_W-1:0]             a_addr,
    input  logic [strb_w(DATA_W)-1:0]   a_wstrb,
    input  logic [DATA_W-1:0]           a_wdata,
    output logic [DATA_W-1:0]           a_rdata,
    input  logic                        b_en,
    input  logic [PA_W-1:0]             b_addr,
    output logic [DATA_W-1:0]           b_rdata
);

    localparam int STRB_W = strb_w(DATA_W);

    logic [DATA_W-1:0] mem_r [2**PA_W];
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;

    // Byte-lane write; only lanes with their strobe set are updated.
    always_ff @(posedge Clock) begin
        for (int k = 0; k < STRB_W; k++) begin
            if (a_wstrb[k]) begin
                mem_r[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
            end
        end
    end

    // CPU read register: samples the pre-write contents and holds between reads.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_rdata_r <= {DATA_W{1'b0}};
        end else if (a_en) begin
            a_rdata_r <= mem_r[a_addr];
        end
    end

    // Video read register; downstream validity tracking qualifies its contents.
    always_ff @(posedge Clock) begin
        if (b_en) begin
            b_rdata_r <= mem_r[b_addr];
        end
    end

    assign a_rdata = a_rdata_r;
    assign b_rdata = b_rdata_r;

endmodule

// File: rtl/vid_palette_multi.sv
// Multi-channel video palette: one CPU port, NCHAN independent lookup channels,
// optional double buffering with a frame-synchronised bank swap.
module vid_palette_multi
    import vid_palette_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int NCHAN      = 2,
    parameter int DOUBLE_BUF = 1,
    parameter int TRANSP_IDX = 0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic [strb_w(DATA_W)-1:0] cpu_wstrb,
    input  logic                      cpu_ren,
    input  logic                      cpu_front,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_rvalid,
    input  logic                      swap_req,
    output logic                      swap_pending,
    output logic                      swap_done,
    input  logic                      frame_start,
    input  logic                      transp_en,
    input  logic [NCHAN*ADDR_W-1:0]   vid_idx,
    input  logic [NCHAN-1:0]          vid_valid,
    output logic [NCHAN*DATA_W-1:0]   vid_color,
    output logic [NCHAN-1:0]          vid_cvalid,
    output logic [NCHAN-1:0]          vid_transp
);

    localparam int BANK_BIT = bank_bit_pos(ADDR_W);
    localparam int PA_W     = ADDR_W + DOUBLE_BUF;
    localparam logic [ADDR_W-1:0] TRANSP_A = ADDR_W'(TRANSP_IDX);

    logic              front_bank_r;
    logic [PA_W-1:0]   cpu_pa_s;
    logic              cpu_rvalid_r;
    logic [DATA_W-1:0] cpu_rdata_s;

    assign cpu_pa_s[ADDR_W-1:0] = cpu_addr;

    if (DOUBLE_BUF != 0) begin : g_dbuf
        swap_state_e state_r;
        swap_state_e state_nxt_s;
        logic        front_nxt_s;
        logic        done_nxt_s;
        logic        done_r;

        // Swap controller state, front-bank selector and swap_done pulse.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                state_r      <= SWAP_IDLE;
                front_bank_r <= 1'b0;
                done_r       <= 1'b0;
            end else begin
                state_r      <= state_nxt_s;
                front_bank_r <= front_nxt_s;
                done_r       <= done_nxt_s;
            end
        end

        // A request waits for frame_start; one arriving with frame_start swaps at once.
        always_comb begin
            state_nxt_s = state_r;
            front_nxt_s = front_bank_r;
            done_nxt_s  = 1'b0;
            case (state_r)
                SWAP_IDLE: begin
                    if (swap_req && frame_start) begin
                        front_nxt_s = ~front_bank_r;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = SWAP_IDLE;
                    end else if (swap_req) begin
                        state_nxt_s = SWAP_PENDING;
                    end else begin
                        state_nxt_s = SWAP_IDLE;
                    end
                end
                SWAP_PENDING: begin
                    if (frame_start) begin
                        front_nxt_s = ~front_bank_r;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = SWAP_IDLE;
                    end else begin
                        state_nxt_s = SWAP_PENDING;
                    end
                end
                default: begin
                    state_nxt_s = SWAP_IDLE;
                end
            endcase
        end

        assign cpu_pa_s[BANK_BIT] = cpu_front ? front_bank_r : ~front_bank_r;
        assign swap_pending       = (state_r == SWAP_PENDING);
        assign swap_done          = done_r;
    end else begin : g_sbuf
        logic swap_unused_s;
        assign swap_unused_s = swap_req ^ frame_start ^ cpu_front;
        assign front_bank_r  = 1'b0;
        assign swap_pending  = 1'b0;
        assign swap_done     = 1'b0;
    end

    // CPU read-valid is a single pulse per accepted read request.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cpu_rvalid_r <= 1'b0;
        end else begin
            cpu_rvalid_r <= cpu_ren;
        end
    end

    assign cpu_rvalid = cpu_rvalid_r;
    assign cpu_rdata  = cpu_rdata_s;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic [ADDR_W-1:0] idx_s;
        logic [PA_W-1:0]   vid_pa_s;
        logic [DATA_W-1:0] ram_q_s;
        logic [DATA_W-1:0] rdata_unused_s;
        logic [DATA_W-1:0] a_rdata_s;
        logic              valid_d1_r;
        logic              transp_d1_r;
        logic [DATA_W-1:0] color_r;
        logic              cvalid_r;
        logic              transp_r;

        assign idx_s = vid_idx[c*ADDR_W +: ADDR_W];

        if (DOUBLE_BUF != 0) begin : g_va
            assign vid_pa_s = {front_bank_r, idx_s};
        end else begin : g_va
            assign vid_pa_s = idx_s;
        end

        if (c == 0) begin : g_rd
            assign cpu_rdata_s    = a_rdata_s;
            assign rdata_unused_s = {DATA_W{1'b0}};
        end else begin : g_rd
            assign rdata_unused_s = a_rdata_s;
        end

        vid_palette_copy #(
            .DATA_W (DATA_W),
            .PA_W   (PA_W)
        ) u_copy (
            .Clock   (Clock),
            .Reset   (Reset),
            .a_en    ((c == 0) ? cpu_ren : 1'b0),
            .a_addr  (cpu_pa_s),
            .a_wstrb (cpu_wstrb),
            .a_wdata (cpu_wdata),
            .a_rdata (a_rdata_s),
            .b_en    (vid_valid[c]),
            .b_addr  (vid_pa_s),
            .b_rdata (ram_q_s)
        );

        // Lookup pipeline: stage 1 tracks the RAM read, stage 2 registers the colour.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                valid_d1_r  <= 1'b0;
                transp_d1_r <= 1'b0;
                cvalid_r    <= 1'b0;
                transp_r    <= 1'b0;
                color_r     <= {DATA_W{1'b0}};
            end else begin
                valid_d1_r  <= vid_valid[c];
                transp_d1_r <= transp_en && (idx_s == TRANSP_A);
                cvalid_r    <= valid_d1_r;
                transp_r    <= valid_d1_r && transp_d1_r;
                if (valid_d1_r) begin
                    color_r <= ram_q_s;
                end
            end
        end

        assign vid_color[c*DATA_W +: DATA_W] = color_r;
        assign vid_cvalid[c]                 = cvalid_r;
        assign vid_transp[c]                 = transp_r;
    end

endmodule
